// File: rtl/imm_ctrl_pkg.sv
// Shared definitions for the ID-stage immediate sequencer: opcodes, format
// encoding, post-shift codes and the skid-buffer entry layout.
package imm_ctrl_pkg;

  localparam int REG_BUS  = 64;
  localparam int IMM1_LEN = 12;
  localparam int IMM2_LEN = 20;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_B    = 3'd3,
    T_U    = 3'd4,
    T_J    = 3'd5,
    T_R    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    SH_0  = 2'd0,
    SH_1  = 2'd1,
    SH_12 = 2'd2
  } shift_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [REG_BUS-1:0] imm;
    imm_type_e          typ;
    logic               illegal;
  } entry_t;

  function automatic logic [5:0] shift_amt(input shift_e sh);
    case (sh)
      SH_1:    return 6'd1;
      SH_12:   return 6'd12;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/imm_ctrl_sext.sv
// Sign-extension unit: widens either the 12-bit or the 20-bit immediate
// field to the register width. Purely combinational; output forced to 0 in reset.
module imm_ctrl_sext
  import imm_ctrl_pkg::*;
(
  input  logic                rst,
  input  logic                immsel,
  input  logic [IMM1_LEN-1:0] imm1,
  input  logic [IMM2_LEN-1:0] imm2,
  output logic [REG_BUS-1:0]  sext_out
);

  always_comb begin
    sext_out = '0;
    if (!rst) begin
      if (immsel)
        sext_out = {{(REG_BUS-IMM1_LEN){imm1[IMM1_LEN-1]}}, imm1};
      else
        sext_out = {{(REG_BUS-IMM2_LEN){imm2[IMM2_LEN-1]}}, imm2};
    end
  end

endmodule

// File: rtl/imm_ctrl.sv
// ID-stage immediate sequencer: decodes the instruction format, builds the
// final 64-bit immediate and queues it in a 2-entry skid buffer toward EX.
//
// state     | meaning
// OCC_EMPTY | no entry held, imm_valid low
// OCC_ONE   | one entry held at head, can still accept
// OCC_FULL  | both entries held, inst_ready low
module imm_ctrl
  import imm_ctrl_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid_i_immctrl,
  input  logic [31:0]          inst_i_immctrl,
  output logic                 inst_ready_o_immctrl,
  input  logic                 flush_i_immctrl,
  input  logic                 imm_ready_i_immctrl,
  output logic                 imm_valid_o_immctrl,
  output logic [REG_BUS-1:0]   imm_o_immctrl,
  output logic [2:0]           type_o_immctrl,
  output logic                 illegal_o_immctrl,
  output logic [ILL_CNT_W-1:0] ill_cnt_o_immctrl
);

  logic                immsel;
  logic [IMM1_LEN-1:0] imm1;
  logic [IMM2_LEN-1:0] imm2;
  shift_e              dec_shift;
  imm_type_e           dec_type;
  logic                dec_illegal;
  logic [REG_BUS-1:0]  sext_out;
  entry_t              new_entry;

  occ_e                occ;
  logic                head;
  logic                tail;
  entry_t              buf_q [2];
  logic [ILL_CNT_W-1:0] ill_cnt;
  logic                imm_valid_q;
  logic                inst_ready_q;
  logic                accept;
  logic                pop;

  always_comb begin
    immsel      = 1'b1;
    imm1        = '0;
    imm2        = '0;
    dec_shift   = SH_0;
    dec_type    = T_NONE;
    dec_illegal = 1'b0;
    case (inst_i_immctrl[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
        imm1     = inst_i_immctrl[31:20];
        dec_type = T_I;
      end
      OP_STORE: begin
        imm1     = {inst_i_immctrl[31:25], inst_i_immctrl[11:7]};
        dec_type = T_S;
      end
      OP_BRANCH: begin
        imm1      = {inst_i_immctrl[31], inst_i_immctrl[7],
                     inst_i_immctrl[30:25], inst_i_immctrl[11:8]};
        dec_shift = SH_1;
        dec_type  = T_B;
      end
      OP_LUI, OP_AUIPC: begin
        immsel    = 1'b0;
        imm2      = inst_i_immctrl[31:12];
        dec_shift = SH_12;
        dec_type  = T_U;
      end
      OP_JAL: begin
        immsel    = 1'b0;
        imm2      = {inst_i_immctrl[31], inst_i_immctrl[19:12],
                     inst_i_immctrl[20], inst_i_immctrl[30:21]};
        dec_shift = SH_1;
        dec_type  = T_J;
      end
      OP_OP, OP_OP32: dec_type = T_R;
      default:        dec_illegal = 1'b1;
    endcase
  end

  imm_ctrl_sext u_sext (
    .rst      (rst),
    .immsel   (immsel),
    .imm1     (imm1),
    .imm2     (imm2),
    .sext_out (sext_out)
  );

  // R-type and illegal leave imm1 at zero, so the shifted result is zero too.
  always_comb begin
    new_entry.imm     = sext_out << shift_amt(dec_shift);
    new_entry.typ     = dec_type;
    new_entry.illegal = dec_illegal;
  end

  assign accept = inst_valid_i_immctrl & inst_ready_q;
  assign pop    = imm_valid_q & imm_ready_i_immctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ          <= OCC_EMPTY;
      head         <= 1'b0;
      tail         <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      ill_cnt      <= '0;
      imm_valid_q  <= 1'b0;
      inst_ready_q <= 1'b1;
    end else if (flush_i_immctrl) begin
      occ          <= OCC_EMPTY;
      head         <= 1'b0;
      tail         <= 1'b0;
      imm_valid_q  <= 1'b0;
      inst_ready_q <= 1'b1;
    end else begin
      if (accept) begin
        buf_q[tail] <= new_entry;
        tail        <= ~tail;
        if (new_entry.illegal && ill_cnt != '1)
          ill_cnt <= ill_cnt + ILL_CNT_W'(1);
      end
      if (pop)
        head <= ~head;
      case (occ)
        OCC_EMPTY: begin
          if (accept) begin
            occ         <= OCC_ONE;
            imm_valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && !pop) begin
            occ          <= OCC_FULL;
            inst_ready_q <= 1'b0;
          end else if (pop && !accept) begin
            occ         <= OCC_EMPTY;
            imm_valid_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            occ          <= OCC_ONE;
            inst_ready_q <= 1'b1;
          end
        end
        default: begin
          occ          <= OCC_EMPTY;
          imm_valid_q  <= 1'b0;
          inst_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign inst_ready_o_immctrl = inst_ready_q;
  assign imm_valid_o_immctrl  = imm_valid_q;
  assign imm_o_immctrl        = buf_q[head].imm;
  assign type_o_immctrl       = buf_q[head].typ;
  assign illegal_o_immctrl    = buf_q[head].illegal;
  assign ill_cnt_o_immctrl    = ill_cnt;

endmodule
